// File: rtl/pipe_issue_arb.sv
// Two-requester in-order issue arbiter with a per-register hazard scoreboard,
// round-robin grant, one-cycle registered issue stage and performance counters.
module pipe_issue_arb #(
  parameter int HAZ   = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [23:0]      req0_instr,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [23:0]      req1_instr,
  output logic             req1_ready,
  input  logic             pipe_stall,
  output logic             iss_valid,
  output logic [3:0]       iss_func,
  output logic [3:0]       iss_rd,
  output logic [3:0]       iss_rs1,
  output logic [3:0]       iss_rs2,
  output logic [7:0]       iss_addr,
  output logic             iss_src,
  output logic             err_func,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [3:0] func;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [7:0] addr;
  } instr_t;

  localparam logic [1:0] HAZ_LD = 2'(HAZ);

  function automatic logic is_legal(input logic [3:0] func);
    return func < 4'd10;
  endfunction

  instr_t     in0, in1, sel;
  logic [1:0] sb [16];
  logic [15:0] busy;
  logic       prio;
  logic       elig0, elig1;
  logic       hs, hs_legal, hs_illegal, gidx;

  assign in0 = instr_t'(req0_instr);
  assign in1 = instr_t'(req1_instr);

  always_comb begin
    busy = '0;
    for (int i = 0; i < 16; i++) busy[i] = (sb[i] != 2'd0);
  end

  // Illegal opcodes bypass the hazard check: they are consumed and dropped.
  assign elig0 = req0_valid && !pipe_stall &&
                 (!is_legal(in0.func) || (!busy[in0.rs1] && !busy[in0.rs2]));
  assign elig1 = req1_valid && !pipe_stall &&
                 (!is_legal(in1.func) || (!busy[in1.rs1] && !busy[in1.rs2]));

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise
    // a path that skips an assignment infers a latch.
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!rst) begin
      if (!prio) begin
        req0_ready = elig0;
        req1_ready = !elig0 && elig1;
      end else begin
        req1_ready = elig1;
        req0_ready = !elig1 && elig0;
      end
    end
  end

  assign hs         = req0_ready | req1_ready;
  assign gidx       = req1_ready;
  assign sel        = gidx ? in1 : in0;
  assign hs_legal   = hs && is_legal(sel.func);
  assign hs_illegal = hs && !is_legal(sel.func);

  // Loading rd takes precedence over the decrement of that same entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the scoreboard array is reset explicitly because stale hazard
      // state would block or wrongly release dependent instructions.
      for (int i = 0; i < 16; i++) sb[i] <= 2'd0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (hs_legal && (sel.rd == 4'(i))) sb[i] <= HAZ_LD;
        else if (!pipe_stall && (sb[i] != 2'd0)) sb[i] <= sb[i] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      prio      <= 1'b0;
      iss_valid <= 1'b0;
      err_func  <= 1'b0;
      iss_func  <= '0;
      iss_rd    <= '0;
      iss_rs1   <= '0;
      iss_rs2   <= '0;
      iss_addr  <= '0;
      iss_src   <= 1'b0;
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      iss_valid <= hs_legal;
      err_func  <= hs_illegal;
      if (hs) prio <= ~gidx;
      if (hs_legal) begin
        iss_func  <= sel.func;
        iss_rd    <= sel.rd;
        iss_rs1   <= sel.rs1;
        iss_rs2   <= sel.rs2;
        iss_addr  <= sel.addr;
        iss_src   <= gidx;
        issue_cnt <= issue_cnt + 1'b1;
      end
      if ((req0_valid || req1_valid) && !hs) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
